// File: rtl/cp0_excp_pkg.sv
// CP0 exception unit shared definitions: register numbers, ExcCodes,
// Status/Cause field positions, vectors and register packing helpers.
package cp0_excp_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_IM  = 8;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_EXC  = 2;
    localparam int CAUSE_IP   = 8;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    function automatic logic [31:0] pack_status(
        input logic [7:0] im,
        input logic       exl,
        input logic       ie
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_BEV] = 1'b1;
        s[STATUS_IM+:8] = im;
        s[STATUS_EXL] = exl;
        s[STATUS_IE] = ie;
        return s;
    endfunction

    function automatic logic [31:0] pack_cause(
        input logic       bd,
        input logic       ti,
        input logic [7:0] ip,
        input logic [4:0] code
    );
        logic [31:0] c;
        c = '0;
        c[CAUSE_BD] = bd;
        c[CAUSE_TI] = ti;
        c[CAUSE_IP+:8] = ip;
        c[CAUSE_EXC+:5] = code;
        return c;
    endfunction

endpackage

// File: rtl/cp0_excp_if.sv
// Memory-stage to CP0 bundle: exception flags, MTC0/MFC0 traffic and
// the flush/redirect response.
interface cp0_excp_if;
    logic [31:0] pc_m;
    logic        in_delayslot_m;
    logic        is_invalid_m;
    logic        syscall_m;
    logic        break_m;
    logic        eret_m;
    logic        overflow_m;
    logic        adel_m;
    logic        ades_m;
    logic [31:0] badaddr_m;
    logic        cp0_we_m;
    logic [4:0]  cp0_waddr_m;
    logic [31:0] cp0_wdata_m;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        exc_flush;
    logic [31:0] exc_pc;
    logic [4:0]  excode;

    modport master (
        output pc_m, in_delayslot_m, is_invalid_m, syscall_m, break_m,
        output eret_m, overflow_m, adel_m, ades_m, badaddr_m,
        output cp0_we_m, cp0_waddr_m, cp0_wdata_m, cp0_raddr,
        input  cp0_rdata, exc_flush, exc_pc, excode
    );

    modport slave (
        input  pc_m, in_delayslot_m, is_invalid_m, syscall_m, break_m,
        input  eret_m, overflow_m, adel_m, ades_m, badaddr_m,
        input  cp0_we_m, cp0_waddr_m, cp0_wdata_m, cp0_raddr,
        output cp0_rdata, exc_flush, exc_pc, excode
    );
endinterface

// File: rtl/cp0_excp_prio.sv
// Fixed-priority exception selector for the memory stage; ERET only
// wins when nothing else is pending.
module cp0_excp_prio
    import cp0_excp_pkg::*;
(
    input  logic       int_req_i,
    input  logic       fetch_adel_i,
    input  logic       ri_i,
    input  logic       sys_i,
    input  logic       bp_i,
    input  logic       ov_i,
    input  logic       adel_i,
    input  logic       ades_i,
    input  logic       eret_i,
    output logic       taken_o,
    output logic [4:0] code_o,
    output logic       is_eret_o,
    output logic       badv_pc_o,
    output logic       badv_data_o
);

    always_comb begin
        taken_o     = 1'b1;
        code_o      = EXC_INT;
        badv_pc_o   = 1'b0;
        badv_data_o = 1'b0;
        if (int_req_i) begin
            code_o = EXC_INT;
        end else if (fetch_adel_i) begin
            code_o    = EXC_ADEL;
            badv_pc_o = 1'b1;
        end else if (ri_i) begin
            code_o = EXC_RI;
        end else if (sys_i) begin
            code_o = EXC_SYS;
        end else if (bp_i) begin
            code_o = EXC_BP;
        end else if (ov_i) begin
            code_o = EXC_OV;
        end else if (adel_i) begin
            code_o      = EXC_ADEL;
            badv_data_o = 1'b1;
        end else if (ades_i) begin
            code_o      = EXC_ADES;
            badv_data_o = 1'b1;
        end else begin
            taken_o = 1'b0;
        end
    end

    assign is_eret_o = eret_i & ~taken_o;

endmodule

// File: rtl/cp0_excp_unit.sv
// CP0 register file with exception/interrupt handling, ERET return,
// Count/Compare timer and MFC0/MTC0 access.
module cp0_excp_unit
    import cp0_excp_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int,
    cp0_excp_if.slave   bus,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] badv_q, badv_d;
    logic        tick_q, tick_d;

    logic [31:0] status_w, cause_w, rdata;
    logic [4:0]  code;
    logic        int_req, taken, is_eret, badv_pc, badv_data;
    logic        flush_any, wr_en;

    assign status_w = pack_status(im_q, exl_q, ie_q);
    assign cause_w  = pack_cause(bd_q, ti_q, {ip_hw_q, ip_sw_q}, code_q);
    assign int_req  = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

    cp0_excp_prio u_prio (
        .int_req_i   (int_req),
        .fetch_adel_i(|bus.pc_m[1:0]),
        .ri_i        (bus.is_invalid_m),
        .sys_i       (bus.syscall_m),
        .bp_i        (bus.break_m),
        .ov_i        (bus.overflow_m),
        .adel_i      (bus.adel_m),
        .ades_i      (bus.ades_m),
        .eret_i      (bus.eret_m),
        .taken_o     (taken),
        .code_o      (code),
        .is_eret_o   (is_eret),
        .badv_pc_o   (badv_pc),
        .badv_data_o (badv_data)
    );

    assign flush_any     = taken | is_eret;
    assign wr_en         = bus.cp0_we_m & ~flush_any;
    assign bus.exc_flush = resetn & flush_any;
    assign bus.excode    = (resetn & taken) ? code : 5'd0;
    assign bus.exc_pc    = taken ? EXC_VECTOR : epc_q;

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_sw_d   = ip_sw_q;
        code_d    = code_q;
        epc_d     = epc_q;
        compare_d = compare_q;
        badv_d    = badv_q;
        tick_d    = ~tick_q;
        count_d   = count_q + {31'd0, tick_q};
        ti_d      = ti_q | (count_q == compare_q);
        ip_hw_d   = {ext_int[5] | ti_q, ext_int[4:0]};
        if (wr_en) begin
            unique case (bus.cp0_waddr_m)
                REG_COUNT: count_d = bus.cp0_wdata_m;
                REG_COMPARE: begin
                    compare_d = bus.cp0_wdata_m;
                    ti_d      = 1'b0;
                end
                REG_STATUS: begin
                    im_d  = bus.cp0_wdata_m[STATUS_IM+:8];
                    exl_d = bus.cp0_wdata_m[STATUS_EXL];
                    ie_d  = bus.cp0_wdata_m[STATUS_IE];
                end
                REG_CAUSE: ip_sw_d = bus.cp0_wdata_m[CAUSE_IP+:2];
                REG_EPC:   epc_d = bus.cp0_wdata_m;
                default: ;
            endcase
        end
        // Exception state capture; MTC0 is already masked by wr_en here.
        if (taken) begin
            exl_d  = 1'b1;
            code_d = code;
            bd_d   = bus.in_delayslot_m;
            epc_d  = bus.in_delayslot_m ? bus.pc_m - 32'd4 : bus.pc_m;
            if (badv_pc) begin
                badv_d = bus.pc_m;
            end else if (badv_data) begin
                badv_d = bus.badaddr_m;
            end
        end else if (is_eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            im_q      <= STATUS_RST[STATUS_IM+:8];
            exl_q     <= STATUS_RST[STATUS_EXL];
            ie_q      <= STATUS_RST[STATUS_IE];
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            ip_hw_q   <= '0;
            ip_sw_q   <= '0;
            code_q    <= '0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            badv_q    <= '0;
            tick_q    <= 1'b0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            ip_hw_q   <= ip_hw_d;
            ip_sw_q   <= ip_sw_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            badv_q    <= badv_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (bus.cp0_raddr)
            REG_BADVADDR: rdata = badv_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = status_w;
            REG_CAUSE:    rdata = cause_w;
            REG_EPC:      rdata = epc_q;
            default:      rdata = '0;
        endcase
    end

    assign bus.cp0_rdata = rdata;
    assign status_o      = status_w;
    assign cause_o       = cause_w;
    assign epc_o         = epc_q;
    assign timer_int     = ti_q;

endmodule
